// File: rtl/btb_update_ctrl.sv
// BTB update controller: queues mispredicted branch/jump resolutions for
// one-per-cycle BTB writes and runs a full-table invalidation sweep on flush.
module btb_update_ctrl #(
    parameter int XLEN     = 32,
    parameter int BTB_SIZE = 16,
    parameter int QDEPTH   = 4,
    localparam int IW      = (BTB_SIZE > 1) ? $clog2(BTB_SIZE) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_is_branch_or_jump,
    input  logic            ex_mispredict,
    output logic            ex_ready,
    input  logic            flush_req,
    output logic            flush_busy,
    output logic            btb_update_enable,
    output logic [XLEN-1:0] btb_pc_update,
    output logic [XLEN-1:0] btb_target_update,
    output logic            btb_is_branch_or_jump,
    output logic            btb_inval_enable,
    output logic [IW-1:0]   btb_inval_index,
    output logic            btb_lookup_enable,
    output logic            debug_state
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] q_pc  [QDEPTH];
    logic [XLEN-1:0] q_tgt [QDEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [IW-1:0]   counter;

    logic queue_full, queue_empty, do_push, do_pop, do_flush, sweep_last;

    // Handshake: a report transfers when ex_valid && ex_ready at a rising edge;
    // ex_ready never depends on ex_valid.
    assign queue_full  = (count == CW'(QDEPTH));
    assign queue_empty = (count == '0);
    assign ex_ready    = (state == IDLE) && !queue_full && !flush_req;
    assign do_push     = ex_valid && ex_ready && ex_is_branch_or_jump && ex_mispredict;
    // A flush discards queued entries, so the head is not written in the flush cycle.
    assign do_pop      = (state == IDLE) && !queue_empty && !flush_req;
    assign do_flush    = (state == IDLE) && flush_req;
    assign sweep_last  = (state == SWEEP) && (counter == IW'(BTB_SIZE - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (flush_req) state_nxt = SWEEP;
            SWEEP:   if (sweep_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        btb_update_enable     = do_pop;
        btb_pc_update         = do_pop ? q_pc[rd_ptr]  : '0;
        btb_target_update     = do_pop ? q_tgt[rd_ptr] : '0;
        btb_is_branch_or_jump = do_pop;
        btb_inval_enable      = (state == SWEEP);
        btb_inval_index       = (state == SWEEP) ? counter : '0;
        flush_busy            = (state == SWEEP);
        btb_lookup_enable     = (state != SWEEP);
        debug_state           = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage needs no reset: it is only observed behind do_pop.
    always_ff @(posedge clk) begin
        if (do_push) begin
            q_pc[wr_ptr]  <= ex_pc;
            q_tgt[wr_ptr] <= ex_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (do_flush || sweep_last) begin
            counter <= '0;
        end else if (state == SWEEP) begin
            counter <= counter + 1'b1;
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: driver feeds a queue-level reference
// model that pushes expectations; a negedge monitor pops and compares.
module tb_btb_update_ctrl;
    localparam int XLEN = 32;
    localparam int BTB_SIZE = 16;
    localparam int QDEPTH = 4;
    localparam int IW = $clog2(BTB_SIZE);

    logic            clk = 1'b0;
    logic            reset;
    logic            ex_valid, ex_is_branch_or_jump, ex_mispredict, flush_req;
    logic [XLEN-1:0] ex_pc, ex_target;
    logic            ex_ready, flush_busy, btb_update_enable, btb_is_branch_or_jump;
    logic            btb_inval_enable, btb_lookup_enable, debug_state;
    logic [XLEN-1:0] btb_pc_update, btb_target_update;
    logic [IW-1:0]   btb_inval_index;

    btb_update_ctrl #(.XLEN(XLEN), .BTB_SIZE(BTB_SIZE), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_is_branch_or_jump(ex_is_branch_or_jump), .ex_mispredict(ex_mispredict),
        .ex_ready(ex_ready), .flush_req(flush_req), .flush_busy(flush_busy),
        .btb_update_enable(btb_update_enable), .btb_pc_update(btb_pc_update),
        .btb_target_update(btb_target_update), .btb_is_branch_or_jump(btb_is_branch_or_jump),
        .btb_inval_enable(btb_inval_enable), .btb_inval_index(btb_inval_index),
        .btb_lookup_enable(btb_lookup_enable), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    // Scoreboard: per-cycle control {ready, busy, upd, inval}, update payloads, sweep indices.
    logic [3:0]        exp_q[$];
    logic [2*XLEN-1:0] upd_q[$];
    logic [IW-1:0]     inval_q[$];

    // Reference model: pending BTB writes as a plain queue, plus sweep cycles left.
    logic [2*XLEN-1:0] model_q[$];
    int                sweep_left = 0;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] tgt,
                               input logic bj, input logic mis, input logic fl);
        logic rdy, busy, upd, inv;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ex_valid = v; ex_pc = pc; ex_target = tgt;
        ex_is_branch_or_jump = bj; ex_mispredict = mis; flush_req = fl;
        busy = (sweep_left > 0);
        rdy  = !busy && (model_q.size() < QDEPTH) && !fl;
        upd  = 1'b0;
        inv  = busy;
        if (busy) begin
            inval_q.push_back(IW'(BTB_SIZE - sweep_left));
            sweep_left--;
        end else if (fl) begin
            model_q.delete();
            sweep_left = BTB_SIZE;
        end else begin
            if (model_q.size() > 0) begin
                upd = 1'b1;
                upd_q.push_back(model_q.pop_front());
            end
            if (v && rdy && bj && mis) model_q.push_back({pc, tgt});
        end
        exp_q.push_back({rdy, busy, upd, inv});
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        ex_valid = 1'b0; flush_req = 1'b0;
        model_q.delete();
        sweep_left = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard away from the active edge.
    initial begin
        logic [3:0]        e;
        logic [2*XLEN-1:0] u;
        logic [IW-1:0]     ix;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_update_enable", btb_update_enable, 0);
                chk("rst_inval_enable", btb_inval_enable, 0);
                chk("rst_inval_index", btb_inval_index, 0);
                chk("rst_pc_update", btb_pc_update, 0);
                chk("rst_target_update", btb_target_update, 0);
                chk("rst_flush_busy", flush_busy, 0);
                chk("rst_lookup_enable", btb_lookup_enable, 1);
                chk("rst_ex_ready", ex_ready, 1);
            end else begin
                chk("exp_q_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ex_ready", ex_ready, e[3]);
                    chk("flush_busy", flush_busy, e[2]);
                    chk("lookup_enable", btb_lookup_enable, !e[2]);
                    chk("debug_state", debug_state, e[2]);
                    chk("update_enable", btb_update_enable, e[1]);
                    chk("inval_enable", btb_inval_enable, e[0]);
                    if (e[1] && upd_q.size() != 0) begin
                        u = upd_q.pop_front();
                        chk("pc_update", btb_pc_update, u[2*XLEN-1:XLEN]);
                        chk("target_update", btb_target_update, u[XLEN-1:0]);
                        chk("update_is_bj", btb_is_branch_or_jump, 1);
                    end else if (!e[1]) begin
                        chk("pc_update_idle", btb_pc_update, 0);
                        chk("target_update_idle", btb_target_update, 0);
                    end
                    if (e[0] && inval_q.size() != 0) begin
                        ix = inval_q.pop_front();
                        chk("inval_index", btb_inval_index, ix);
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; ex_pc = '0; ex_target = '0;
        ex_is_branch_or_jump = 1'b0; ex_mispredict = 1'b0; flush_req = 1'b0;
        repeat (2) @(posedge clk);

        // Single mispredict: update one cycle after acceptance, then quiet.
        idle(1);
        drive_cycle(1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 1'b0);
        idle(3);

        // Back-to-back mispredicts drain in order.
        for (int i = 0; i < 5; i++)
            drive_cycle(1'b1, 32'h1000 + 4 * i, 32'h2000 + 8 * i, 1'b1, 1'b1, 1'b0);
        idle(2);

        // Correctly predicted or non-branch reports produce no writes.
        drive_cycle(1'b1, 32'h300, 32'h400, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h304, 32'h404, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h308, 32'h408, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Flush with work pending: pending entry dropped, full sweep follows.
        drive_cycle(1'b1, 32'h500, 32'h600, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b1, 32'h504, 32'h604, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(BTB_SIZE + 2);

        // Flush and report in the same cycle: flush wins.
        drive_cycle(1'b1, 32'h700, 32'h800, 1'b1, 1'b1, 1'b1);
        idle(BTB_SIZE + 2);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++)
            drive_cycle($urandom_range(0, 9) < 7, $urandom, $urandom,
                        $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                        $urandom_range(0, 39) == 0);
        idle(BTB_SIZE + 2);

        // Reset while the sweep is presenting index 7.
        drive_cycle(1'b1, 32'h900, 32'ha00, 1'b1, 1'b1, 1'b0);
        drive_cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(7);
        reset_cycle();
        drive_cycle(1'b1, 32'hb00, 32'hc00, 1'b1, 1'b1, 1'b0);
        idle(4);

        @(negedge clk);
        #1;
        chk("exp_q_drained", exp_q.size(), 0);
        chk("upd_q_drained", upd_q.size(), 0);
        chk("inval_q_drained", inval_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
